// File: rtl/bpu_pkg.sv
// Shared BPU definitions: chooser counter encoding, queue entry layout and
// the saturating step functions used by the PHT updaters.
package bpu_pkg;

  // Chooser counter encoding; bit1 ^ bit0 selects the global component.
  localparam logic [1:0] CPHT_SB = 2'b11;
  localparam logic [1:0] CPHT_WB = 2'b00;
  localparam logic [1:0] CPHT_WG = 2'b01;
  localparam logic [1:0] CPHT_SG = 2'b10;

  // Chooser table index width (256-entry table).
  localparam int CPHT_ADDR_W = 8;

  // Snapshot of a chooser entry taken at prediction time.
  typedef struct packed {
    logic [CPHT_ADDR_W-1:0] addr;
    logic [1:0]             cnt;
    logic                   vld;
  } cpht_entry_t;

  // One step toward the global component, saturating at strong_g.
  function automatic logic [1:0] cpht_inc_g(input logic [1:0] c);
    case (c)
      CPHT_SB: return CPHT_WB;
      CPHT_WB: return CPHT_WG;
      default: return CPHT_SG;
    endcase
  endfunction

  // One step toward the bimodal component, saturating at strong_b.
  function automatic logic [1:0] cpht_inc_b(input logic [1:0] c);
    case (c)
      CPHT_SG: return CPHT_WG;
      CPHT_WG: return CPHT_WB;
      default: return CPHT_SB;
    endcase
  endfunction

endpackage

// File: rtl/cpht_sat_update.sv
// Combinational 2-bit counter update: picks the base value, applies the
// direction implied by the two component outcomes and flags whether the
// table entry needs a write at all.
module cpht_sat_update
  import bpu_pkg::*;
(
  input  logic [1:0] i_base_cnt,
  input  logic       i_base_vld,
  input  logic       i_g_ok,
  input  logic       i_b_ok,
  output logic [1:0] o_new_cnt,
  output logic       o_wr_req
);

  logic [1:0] w_base;

  // An invalid entry starts from strong_b, as if freshly allocated.
  assign w_base = i_base_vld ? i_base_cnt : CPHT_SB;

  // Disagreement moves the counter; agreement only writes to allocate.
  always_comb begin
    o_new_cnt = w_base;
    o_wr_req  = ~i_base_vld;
    if (i_g_ok && !i_b_ok) begin
      o_new_cnt = cpht_inc_g(w_base);
      o_wr_req  = 1'b1;
    end else if (i_b_ok && !i_g_ok) begin
      o_new_cnt = cpht_inc_b(w_base);
      o_wr_req  = 1'b1;
    end
  end

endmodule

// File: rtl/cpht_update_queue.sv
// Choice-PHT update queue: holds chooser snapshots from fetch until the
// branch resolves, then issues a registered write of the updated counter.
module cpht_update_queue
  import bpu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = CPHT_ADDR_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     stallreq,
  input  logic                     push_valid,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [1:0]               push_cnt,
  input  logic                     push_cnt_vld,
  input  logic                     resolve_valid,
  input  logic                     resolve_b_ok,
  input  logic                     resolve_g_ok,
  input  logic                     flush,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [1:0]               wr_cnt,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  cpht_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [1:0]        r_wr_cnt;
  logic              r_ovf;
  logic              r_unf;

  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_pop;
  cpht_entry_t       w_head;
  logic [ADDR_W-1:0] w_head_addr;
  logic              w_head_fwd;
  logic [1:0]        w_base_cnt;
  logic              w_base_vld;
  logic [1:0]        w_new_cnt;
  logic              w_wr_req;
  logic              w_push_fwd;
  cpht_entry_t       w_push_entry;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Full is judged on the occupancy before any same-cycle pop.
  assign w_push_ok = push_valid & ~w_full & ~stallreq & ~flush;
  assign w_pop     = resolve_valid & ~w_empty & ~stallreq;

  assign w_head      = r_mem[r_rptr];
  assign w_head_addr = ADDR_W'(w_head.addr);

  // The write currently on the table port is newer than the head snapshot.
  assign w_head_fwd = r_wr_en & (r_wr_addr == w_head_addr);
  assign w_base_cnt = w_head_fwd ? r_wr_cnt : w_head.cnt;
  assign w_base_vld = w_head_fwd | w_head.vld;

  // Likewise a snapshot taken while its entry is being written is stale.
  assign w_push_fwd = r_wr_en & (r_wr_addr == push_addr);

  // Assemble the snapshot stored on push.
  always_comb begin
    w_push_entry      = '0;
    w_push_entry.addr = CPHT_ADDR_W'(push_addr);
    w_push_entry.cnt  = w_push_fwd ? r_wr_cnt : push_cnt;
    w_push_entry.vld  = w_push_fwd | push_cnt_vld;
  end

  cpht_sat_update u_sat (
    .i_base_cnt (w_base_cnt),
    .i_base_vld (w_base_vld),
    .i_g_ok     (resolve_g_ok),
    .i_b_ok     (resolve_b_ok),
    .o_new_cnt  (w_new_cnt),
    .o_wr_req   (w_wr_req)
  );

  // Snapshot storage; contents are never cleared, pointers define validity.
  always_ff @(posedge clk) begin
    if (resetn && w_push_ok) begin
      r_mem[r_wptr] <= w_push_entry;
    end
  end

  // Pointers, occupancy, write port and error pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_cnt  <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_wr_en <= w_pop & w_wr_req;
      if (w_pop && w_wr_req) begin
        r_wr_addr <= w_head_addr;
        r_wr_cnt  <= w_new_cnt;
      end
      r_ovf <= ~stallreq & push_valid & w_full;
      r_unf <= ~stallreq & resolve_valid & w_empty;
      if (!stallreq && flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)     r_rptr <= r_rptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_cnt    = r_wr_cnt;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_cpht_update_queue.sv
// Self-checking bench for cpht_update_queue: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_cpht_update_queue;
  import bpu_pkg::*;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 8;

  logic                   clk;
  logic                   resetn;
  logic                   stallreq;
  logic                   push_valid;
  logic [ADDR_W-1:0]      push_addr;
  logic [1:0]             push_cnt;
  logic                   push_cnt_vld;
  logic                   resolve_valid;
  logic                   resolve_b_ok;
  logic                   resolve_g_ok;
  logic                   flush;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [1:0]             wr_cnt;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   underflow;

  cpht_update_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .stallreq      (stallreq),
    .push_valid    (push_valid),
    .push_addr     (push_addr),
    .push_cnt      (push_cnt),
    .push_cnt_vld  (push_cnt_vld),
    .resolve_valid (resolve_valid),
    .resolve_b_ok  (resolve_b_ok),
    .resolve_g_ok  (resolve_g_ok),
    .flush         (flush),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_cnt        (wr_cnt),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] addr;
    logic [1:0] cnt;
    logic       vld;
  } ment_t;

  ment_t      mq[$];
  logic       m_wr_en   = 1'b0;
  logic [7:0] m_wr_addr = '0;
  logic [1:0] m_wr_cnt  = '0;
  logic       m_ovf     = 1'b0;
  logic       m_unf     = 1'b0;
  bit         started   = 1'b0;

  // Chooser states ordered from strong bimodal (0) to strong global (3).
  logic [1:0] scale [4] = '{2'b11, 2'b00, 2'b01, 2'b10};

  function automatic int pos_of(input logic [1:0] c);
    for (int k = 0; k < 4; k++) if (scale[k] == c) return k;
    return 0;
  endfunction

  ment_t      e;
  ment_t      ne;
  logic       was_full, was_empty, cw_en, bv, nw;
  logic [7:0] cw_a;
  logic [1:0] cw_c, b, nc;
  int         p;

  always @(posedge clk) begin
    if (!resetn) begin
      mq.delete();
      m_wr_en = 0; m_wr_addr = 0; m_wr_cnt = 0; m_ovf = 0; m_unf = 0;
    end else if (stallreq) begin
      m_wr_en = 0; m_ovf = 0; m_unf = 0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      cw_en = m_wr_en; cw_a = m_wr_addr; cw_c = m_wr_cnt;
      nw = 0;
      if (resolve_valid && !was_empty) begin
        e = mq.pop_front();
        if (cw_en && cw_a == e.addr) begin b = cw_c; bv = 1; end
        else begin b = e.vld ? e.cnt : 2'b11; bv = e.vld; end
        p = pos_of(b);
        nc = b;
        if (resolve_g_ok && !resolve_b_ok) begin
          nw = 1; nc = scale[(p < 3) ? p + 1 : 3];
        end else if (resolve_b_ok && !resolve_g_ok) begin
          nw = 1; nc = scale[(p > 0) ? p - 1 : 0];
        end else if (!bv) begin
          nw = 1;
        end
        if (nw) begin m_wr_addr = e.addr; m_wr_cnt = nc; end
      end
      m_wr_en = nw;
      if (push_valid && !was_full && !flush) begin
        ne.addr = push_addr;
        if (cw_en && cw_a == push_addr) begin ne.cnt = cw_c; ne.vld = 1; end
        else begin ne.cnt = push_cnt; ne.vld = push_cnt_vld; end
        mq.push_back(ne);
      end
      if (flush) mq.delete();
      m_ovf = push_valid && was_full;
      m_unf = resolve_valid && was_empty;
    end
    started = 1'b1;
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      check("wr_en",     wr_en,     m_wr_en);
      check("wr_addr",   wr_addr,   m_wr_addr);
      check("wr_cnt",    wr_cnt,    m_wr_cnt);
      check("count",     count,     mq.size());
      check("full",      full,      mq.size() == DEPTH);
      check("empty",     empty,     mq.size() == 0);
      check("overflow",  overflow,  m_ovf);
      check("underflow", underflow, m_unf);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_in();
    stallreq = 0; push_valid = 0; push_addr = 0; push_cnt = 0; push_cnt_vld = 0;
    resolve_valid = 0; resolve_b_ok = 0; resolve_g_ok = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic push(input logic [7:0] a, input logic [1:0] c, input logic v);
    push_valid = 1; push_addr = a; push_cnt = c; push_cnt_vld = v;
  endtask

  task automatic resolve(input logic g, input logic bk);
    resolve_valid = 1; resolve_g_ok = g; resolve_b_ok = bk;
  endtask

  initial begin
    clear_in();
    resetn = 0;
    tick(); tick();
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_full",  full,  0);
    resetn = 1;
    tick();

    // Basic toward-global update.
    push(8'h12, 2'b00, 1); tick();
    resolve(1, 0); tick();
    check("t1_wr_en", wr_en, 1);
    check("t1_addr",  wr_addr, 8'h12);
    check("t1_cnt",   wr_cnt, 2'b01);
    check("t1_empty", empty, 1);

    // Allocation write, then push-side forwarding of that write.
    push(8'h40, 2'b10, 0); tick();
    resolve(1, 1); tick();
    check("t2_wr_en", wr_en, 1);
    check("t2_addr",  wr_addr, 8'h40);
    check("t2_cnt",   wr_cnt, 2'b11);
    push(8'h40, 2'b00, 0); tick();
    resolve(1, 1); tick();
    check("t2_fwd_nowrite", wr_en, 0);

    // Back-to-back resolves to the same entry use the forwarded base.
    push(8'h05, 2'b01, 1); tick();
    push(8'h05, 2'b01, 1); tick();
    resolve(1, 0); tick();
    check("t3_cnt0", wr_cnt, 2'b10);
    resolve(1, 0); tick();
    check("t3_cnt1", wr_cnt, 2'b10);
    check("t3_en1",  wr_en, 1);
    push(8'h06, 2'b00, 1); tick();
    push(8'h06, 2'b00, 1); tick();
    resolve(1, 0); tick();
    check("t3b_cnt0", wr_cnt, 2'b01);
    resolve(1, 0); tick();
    check("t3b_cnt1", wr_cnt, 2'b10);

    // Fill, overflow, drain in order across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) begin
      push(8'h80 + 8'(i), 2'(i), 1); tick();
    end
    check("t4_full",  full, 1);
    check("t4_count", count, DEPTH);
    push(8'h99, 2'b00, 1); tick();
    check("t4_ovf",   overflow, 1);
    check("t4_count_hold", count, DEPTH);
    tick();
    check("t4_ovf_clr", overflow, 0);
    for (int i = 0; i < DEPTH; i++) begin
      resolve(1, 0); tick();
      check("t4_order", wr_addr, 8'h80 + 8'(i));
    end
    check("t4_empty", empty, 1);

    // Resolve plus flush plus push in the same cycle.
    push(8'h30, 2'b01, 1); tick();
    push(8'h31, 2'b01, 1); tick();
    push(8'h32, 2'b01, 1); tick();
    resolve(0, 1); flush = 1; push(8'h33, 2'b01, 1); tick();
    check("t5_wr_en", wr_en, 1);
    check("t5_addr",  wr_addr, 8'h30);
    check("t5_cnt",   wr_cnt, 2'b00);
    check("t5_count", count, 0);
    tick();
    check("t5_count_after", count, 0);

    // Stall freezes everything; release yields exactly one pop.
    push(8'h60, 2'b10, 1); tick();
    push(8'h61, 2'b01, 1); tick();
    for (int i = 0; i < 3; i++) begin
      stallreq = 1; resolve(0, 1); tick();
      check("t6_stall_en", wr_en, 0);
      check("t6_stall_count", count, 2);
    end
    resolve(0, 1); tick();
    check("t6_rel_en",   wr_en, 1);
    check("t6_rel_addr", wr_addr, 8'h60);
    check("t6_rel_cnt",  wr_cnt, 2'b01);
    check("t6_rel_count", count, 1);
    resolve(0, 1); tick();
    check("t6_addr2", wr_addr, 8'h61);
    check("t6_cnt2",  wr_cnt, 2'b00);
    resolve(1, 0); tick();
    check("t6_unf",    underflow, 1);
    check("t6_unf_en", wr_en, 0);
    tick();
    check("t6_unf_clr", underflow, 0);

    // Reset mid-operation drops pending entries.
    push(8'h70, 2'b00, 1); tick();
    push(8'h71, 2'b00, 1); tick();
    resetn = 0; tick();
    resetn = 1;
    check("t7_empty", empty, 1);
    check("t7_count", count, 0);
    resolve(1, 0); tick();
    check("t7_unf",  underflow, 1);
    check("t7_noen", wr_en, 0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
